// File: rtl/cpu_fetch_queue.sv
// Multi-entry fetch-to-decode instruction queue: circular buffer with valid/ready on both
// sides, same-cycle flush, optional empty-bypass and occupancy/almost-full outputs.
module cpu_fetch_queue #(
    parameter int DW          = 64,
    parameter int DEPTH       = 4,
    parameter int ALMOST_FULL = 3,
    parameter int BYPASS      = 0
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [DW-1:0]                i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [DW-1:0]                o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic empty, full, bypass_path;
    logic push, pop, pass_thru, store, drain;

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == CW'(DEPTH));
        bypass_path = (BYPASS != 0) && empty;
        o_ready     = !full;
    end

    // Outputs are gated by the live reset so nothing leaks through the bypass path while held in reset.
    always_comb begin
        o_valid = 1'b0;
        o_data  = '0;
        if (i_reset) begin
            if (bypass_path) begin
                o_valid = i_valid && !i_flush;
                o_data  = i_data;
            end else begin
                o_valid = !empty && !i_flush;
                if (!empty) begin
                    o_data = mem_q[rd_ptr_q];
                end
            end
        end
    end

    // A bypassed entry is consumed in the same cycle it arrives and never touches storage.
    always_comb begin
        push      = i_valid && !full && !i_flush;
        pop       = o_valid && i_ready;
        pass_thru = bypass_path && pop;
        store     = push && !pass_thru;
        drain     = pop && !pass_thru;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (drain) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({store, drain})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clock) begin
        if (store) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    always_comb begin
        o_count       = count_q;
        o_almost_full = (count_q >= CW'(ALMOST_FULL));
    end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Bench for cpu_fetch_queue: one non-bypass and one bypass instance share stimulus,
// each checked every cycle against a queue-based reference plus literal expectations.
module tb_cpu_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        vld_in;
    logic [63:0] dat_in;
    logic        rdy_in;

    logic        rdy0, vld0, af0;
    logic [63:0] dat0;
    logic [2:0]  cnt0;
    logic        rdy1, vld1, af1;
    logic [63:0] dat1;
    logic [2:0]  cnt1;

    int checks = 0;
    int errors = 0;

    logic [63:0] mq [2][$];
    logic [63:0] pops0 [$];

    cpu_fetch_queue #(.DW(64), .DEPTH(4), .ALMOST_FULL(3), .BYPASS(0)) u_dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(vld_in),
        .o_ready(rdy0), .i_data(dat_in), .o_valid(vld0), .i_ready(rdy_in),
        .o_data(dat0), .o_count(cnt0), .o_almost_full(af0)
    );

    cpu_fetch_queue #(.DW(64), .DEPTH(4), .ALMOST_FULL(3), .BYPASS(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_flush(flush), .i_valid(vld_in),
        .o_ready(rdy1), .i_data(dat_in), .o_valid(vld1), .i_ready(rdy_in),
        .o_data(dat1), .o_count(cnt1), .o_almost_full(af1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Reference model: compare on the falling edge, then advance to the state after the next rising edge.
    always @(negedge clk) begin
        int n;
        logic ev, er, ea, push, pop;
        logic [63:0] ed;
        logic av, ar, aa;
        logic [63:0] ad;
        logic [2:0] ac;
        for (int b = 0; b < 2; b++) begin
            av = b ? vld1 : vld0;
            ar = b ? rdy1 : rdy0;
            aa = b ? af1 : af0;
            ad = b ? dat1 : dat0;
            ac = b ? cnt1 : cnt0;
            if (!rst_n) begin
                mq[b].delete();
                chk($sformatf("dut%0d rst valid", b), {63'd0, av}, 64'd0);
                chk($sformatf("dut%0d rst ready", b), {63'd0, ar}, 64'd1);
                chk($sformatf("dut%0d rst count", b), {61'd0, ac}, 64'd0);
                chk($sformatf("dut%0d rst afull", b), {63'd0, aa}, 64'd0);
                chk($sformatf("dut%0d rst data", b), ad, 64'd0);
            end else begin
                n  = mq[b].size();
                er = (n < 4);
                ea = (n >= 3);
                if (b == 1 && n == 0) begin
                    ev = vld_in && !flush;
                    ed = dat_in;
                end else begin
                    ev = (n != 0) && !flush;
                    ed = (n != 0) ? mq[b][0] : 64'd0;
                end
                chk($sformatf("dut%0d valid", b), {63'd0, av}, {63'd0, ev});
                chk($sformatf("dut%0d ready", b), {63'd0, ar}, {63'd0, er});
                chk($sformatf("dut%0d count", b), {61'd0, ac}, 64'(n));
                chk($sformatf("dut%0d afull", b), {63'd0, aa}, {63'd0, ea});
                if (ev) chk($sformatf("dut%0d data", b), ad, ed);
                push = vld_in && er && !flush;
                pop  = ev && rdy_in;
                if (b == 0 && pop) pops0.push_back(ed);
                if (flush) begin
                    mq[b].delete();
                end else if (!(pop && n == 0)) begin
                    if (pop) void'(mq[b].pop_front());
                    if (push) mq[b].push_back(dat_in);
                end
            end
        end
    end

    task automatic drv(input logic v, input logic [63:0] d, input logic r, input logic f);
        vld_in = v;
        dat_in = d;
        rdy_in = r;
        flush  = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drv(1'b1, 64'h99, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold rst vld0", {63'd0, vld0}, 64'd0);
            chk("hold rst rdy0", {63'd0, rdy0}, 64'd1);
            chk("hold rst cnt0", {61'd0, cnt0}, 64'd0);
            chk("hold rst vld1", {63'd0, vld1}, 64'd0);
        end

        // Fill with decode stalled, then drain.
        rst_n = 1'b1;
        drv(1'b1, 64'h10, 1'b0, 1'b0);
        #1 chk("first push latency", {63'd0, vld0}, 64'd0);
        tick();
        chk("first out vld", {63'd0, vld0}, 64'd1);
        chk("first out data", dat0, 64'h10);
        chk("first out cnt", {61'd0, cnt0}, 64'd1);
        drv(1'b1, 64'h11, 1'b0, 1'b0); tick();
        chk("afull at 2", {63'd0, af0}, 64'd0);
        drv(1'b1, 64'h12, 1'b0, 1'b0); tick();
        chk("afull at 3", {63'd0, af0}, 64'd1);
        drv(1'b1, 64'h13, 1'b0, 1'b0); tick();
        chk("full cnt", {61'd0, cnt0}, 64'd4);
        chk("full rdy", {63'd0, rdy0}, 64'd0);
        drv(1'b1, 64'h14, 1'b0, 1'b0); tick(); tick();
        chk("held off cnt", {61'd0, cnt0}, 64'd4);
        drv(1'b1, 64'h14, 1'b1, 1'b0);
        #1 chk("full pop rdy", {63'd0, rdy0}, 64'd0);
        chk("full pop head", dat0, 64'h10);
        tick();
        chk("full pop cnt", {61'd0, cnt0}, 64'd3);
        chk("after pop rdy", {63'd0, rdy0}, 64'd1);
        tick();
        chk("push+pop cnt", {61'd0, cnt0}, 64'd3);
        drv(1'b0, 64'h0, 1'b1, 1'b0);
        tick(); tick(); tick();
        chk("drained cnt", {61'd0, cnt0}, 64'd0);
        chk("drain len", 64'(pops0.size()), 64'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < pops0.size()) chk("drain order", pops0[i], 64'h10 + 64'(i));
        end
        pops0.delete();

        // Wrap-around at a steady occupancy of two.
        drv(1'b1, 64'h20, 1'b0, 1'b0); tick();
        drv(1'b1, 64'h21, 1'b0, 1'b0); tick();
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 64'h22 + 64'(i), 1'b1, 1'b0);
            tick();
            chk("wrap cnt", {61'd0, cnt0}, 64'd2);
        end
        drv(1'b0, 64'h0, 1'b1, 1'b0); tick(); tick();
        chk("wrap len", 64'(pops0.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (i < pops0.size()) chk("wrap order", pops0[i], 64'h20 + 64'(i));
        end
        pops0.delete();

        // Flush with a concurrent push of 0xAA.
        drv(1'b1, 64'h30, 1'b0, 1'b0); tick();
        drv(1'b1, 64'h31, 1'b0, 1'b0); tick();
        drv(1'b1, 64'h32, 1'b0, 1'b0); tick();
        chk("pre-flush cnt", {61'd0, cnt0}, 64'd3);
        drv(1'b1, 64'hAA, 1'b1, 1'b1);
        #1 chk("flush vld0", {63'd0, vld0}, 64'd0);
        chk("flush vld1", {63'd0, vld1}, 64'd0);
        tick();
        drv(1'b0, 64'h0, 1'b1, 1'b0);
        #1 chk("post-flush cnt0", {61'd0, cnt0}, 64'd0);
        chk("post-flush cnt1", {61'd0, cnt1}, 64'd0);
        tick(); tick();
        chk("no AA popped", 64'(pops0.size()), 64'd0);

        // Bypass pass-through, then bypass-stored.
        drv(1'b1, 64'h55, 1'b1, 1'b0);
        #1 chk("byp vld1", {63'd0, vld1}, 64'd1);
        chk("byp dat1", dat1, 64'h55);
        chk("byp cnt1", {61'd0, cnt1}, 64'd0);
        chk("nobyp vld0", {63'd0, vld0}, 64'd0);
        tick();
        drv(1'b0, 64'h0, 1'b0, 1'b0);
        #1 chk("byp pass cnt1", {61'd0, cnt1}, 64'd0);
        chk("nobyp stored cnt0", {61'd0, cnt0}, 64'd1);
        drv(1'b0, 64'h0, 1'b1, 1'b0); tick();
        drv(1'b1, 64'h55, 1'b0, 1'b0); tick();
        drv(1'b0, 64'h0, 1'b0, 1'b0);
        #1 chk("byp stored cnt1", {61'd0, cnt1}, 64'd1);
        chk("byp stored dat1", dat1, 64'h55);
        chk("byp stored vld1", {63'd0, vld1}, 64'd1);

        // Reset asserted mid-operation with entries queued.
        drv(1'b1, 64'h66, 1'b0, 1'b0); tick();
        drv(1'b0, 64'h0, 1'b0, 1'b0);
        chk("pre-rst cnt0", {61'd0, cnt0}, 64'd2);
        #2 rst_n = 1'b0;
        #1 chk("async rst cnt0", {61'd0, cnt0}, 64'd0);
        chk("async rst vld1", {63'd0, vld1}, 64'd0);
        chk("async rst rdy0", {63'd0, rdy0}, 64'd1);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("post rst cnt1", {61'd0, cnt1}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
